// File: rtl/sample_sched_eval_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_sched_eval_if : streaming in/out handshake bundle (Rev 1.0)        |
// +--------------------------------------------------------------------------+
interface sample_sched_eval_if #(
   parameter int STEP_W = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        in_data;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        out_data;
   logic [STEP_W-1:0] dbg_step;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, dbg_step
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, dbg_step
   );
endinterface
`default_nettype wire

// File: rtl/sample_sched_eval.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_sched_eval : 5-step AND/OR/NOT time-multiplexed netlist evaluator  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module sample_sched_eval #(
   parameter bit HOLD_RESULT = 1'b1,
   parameter int STEP_W      = 3
) (
   input  logic               clk,
   input  logic               rst,
   sample_sched_eval_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [STEP_W-1:0] C_STEP1 = STEP_W'(1);
   localparam logic [STEP_W-1:0] C_STEP2 = STEP_W'(2);
   localparam logic [STEP_W-1:0] C_STEP3 = STEP_W'(3);
   localparam logic [STEP_W-1:0] C_STEP4 = STEP_W'(4);
   localparam logic [STEP_W-1:0] C_STEP5 = STEP_W'(5);

   logic [1:0]        state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [5:0]        in_q;
   logic              g_q, h_q, i_q, j_q, k_q, l_q, m_q, n_q, o_q, p_q, q_q;
   logic [2:0]        held_q;

   logic              in_ready_c, out_valid_c, accept;
   logic [2:0]        out_data_c;
   logic [STEP_W-1:0] dbg_c;
   logic              and_x, and_y, and_z, and_r;
   logic              or_x, or_y, or_z, or_r;
   logic              not_x, not_r;

   wire a = in_q[0];
   wire b = in_q[1];
   wire c = in_q[2];
   wire d = in_q[3];
   wire e = in_q[4];
   wire f = in_q[5];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
               step_d  = C_STEP1;
            end
         end
         ST_EXEC: begin
            if (step_q == C_STEP5) begin
               state_d = ST_DONE;
               step_d  = '0;
            end else begin
               step_d  = step_q + C_STEP1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = accept ? ST_EXEC : ST_IDLE;
               step_d  = accept ? C_STEP1 : '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            step_d  = '0;
         end
      endcase
   end

   // Result is live from the node registers in DONE, otherwise the value captured at the last handshake.
   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      out_data_c  = held_q;
      dbg_c       = '0;
      case (state_q)
         ST_IDLE: in_ready_c = 1'b1;
         ST_EXEC: dbg_c      = step_q;
         ST_DONE: begin
            out_valid_c = 1'b1;
            in_ready_c  = bus.out_ready;
            out_data_c  = {q_q, p_q, o_q};
         end
         default: ;
      endcase
   end

   assign accept        = bus.in_valid & in_ready_c;
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_data_c;
   assign bus.dbg_step  = dbg_c;

   // Operand steering for the shared units; idle inputs are the identity so 2-input ops reuse the 3-input gate.
   always_comb begin
      and_x = 1'b1; and_y = 1'b1; and_z = 1'b1;
      or_x  = 1'b0; or_y  = 1'b0; or_z  = 1'b0;
      not_x = 1'b0;
      if (state_q == ST_EXEC) begin
         case (step_q)
            C_STEP1: begin
               and_x = a; and_y = c;
               or_x  = d; or_y  = e; or_z = f;
               not_x = c;
            end
            C_STEP2: begin
               and_x = h_q; and_y = j_q; and_z = i_q;
               or_x  = a;   or_y  = d;
            end
            C_STEP3: begin
               and_x = i_q; and_y = j_q;
               or_x  = g_q; or_y  = h_q; or_z = i_q;
               not_x = g_q;
            end
            C_STEP4: begin
               and_x = l_q; and_y = m_q;
            end
            C_STEP5: begin
               and_x = b; and_y = k_q; and_z = h_q;
               not_x = n_q;
            end
            default: ;
         endcase
      end
   end

   assign and_r = and_x & and_y & and_z;
   assign or_r  = or_x | or_y | or_z;
   assign not_r = ~not_x;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q   <= '0;
         g_q    <= 1'b0; h_q <= 1'b0; i_q <= 1'b0; j_q <= 1'b0;
         k_q    <= 1'b0; l_q <= 1'b0; m_q <= 1'b0; n_q <= 1'b0;
         o_q    <= 1'b0; p_q <= 1'b0; q_q <= 1'b0;
         held_q <= '0;
      end else begin
         if (accept) begin
            in_q <= bus.in_data;
         end
         if (state_q == ST_DONE && bus.out_ready) begin
            held_q <= HOLD_RESULT ? {q_q, p_q, o_q} : 3'b000;
         end
         if (state_q == ST_EXEC) begin
            case (step_q)
               C_STEP1: begin h_q <= and_r; j_q <= or_r; i_q <= not_r; end
               C_STEP2: begin l_q <= and_r; g_q <= or_r; end
               C_STEP3: begin m_q <= and_r; k_q <= or_r; p_q <= not_r; end
               C_STEP4: begin n_q <= and_r; end
               C_STEP5: begin o_q <= and_r; q_q <= not_r; end
               default: ;
            endcase
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sample_sched_eval.sv
`default_nettype none
// Directed bench for sample_sched_eval: vector table plus backpressure, back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_sample_sched_eval;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sample_sched_eval_if #(.STEP_W(3)) bus ();
   sample_sched_eval #(.HOLD_RESULT(1'b1), .STEP_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [5:0] din;
      logic [2:0] expd;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts from IDLE, runs one evaluation and hands the result off with out_ready.
   task automatic run_one(input logic [5:0] din, input logic [2:0] expd, input string nm);
      bus.in_valid  = 1'b1;
      bus.in_data   = din;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      for (int s = 1; s <= 5; s++) begin
         chk({nm, " dbg_step"}, 32'(bus.dbg_step), 32'(s));
         if (s == 1) chk({nm, " in_ready exec"}, 32'(bus.in_ready), 0);
         tick();
      end
      chk({nm, " out_valid"}, 32'(bus.out_valid), 1);
      chk({nm, " out_data"}, 32'(bus.out_data), 32'(expd));
      chk({nm, " q invariant"}, 32'(dut.q_q), 1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({nm, " idle after"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
      chk({nm, " hold"}, 32'(bus.out_data), 32'(expd));
   endtask

   initial begin
      vec_t vecs[6];
      logic seen;
      vecs[0] = '{din: 6'b000000, expd: 3'b110};
      vecs[1] = '{din: 6'b111111, expd: 3'b101};
      vecs[2] = '{din: 6'b000101, expd: 3'b100};
      vecs[3] = '{din: 6'b110010, expd: 3'b110};
      vecs[4] = '{din: 6'b000011, expd: 3'b100};
      vecs[5] = '{din: 6'b100111, expd: 3'b101};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset in_ready", 32'(bus.in_ready), 1);
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset out_data", 32'(bus.out_data), 0);
      chk("reset dbg_step", 32'(bus.dbg_step), 0);

      run_one(6'b000111, 3'b101, "abc");
      run_one(6'b001000, 3'b100, "d");
      chk("probe m", 32'(dut.m_q), 1);
      chk("probe k", 32'(dut.k_q), 1);
      chk("probe n", 32'(dut.n_q), 0);

      for (int v = 0; v < 6; v++) begin
         run_one(vecs[v].din, vecs[v].expd, $sformatf("vec%0d", v));
      end

      // Backpressure: result must sit still while out_ready is low.
      bus.in_valid = 1'b1;
      bus.in_data  = 6'b000010;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      for (int w = 0; w < 4; w++) begin
         chk("bp out_valid", 32'(bus.out_valid), 1);
         chk("bp out_data", 32'(bus.out_data), 32'b110);
         chk("bp in_ready", 32'(bus.in_ready), 0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp to idle", 32'({bus.out_valid, bus.in_ready, bus.dbg_step}), 32'b0_1_000);

      // Back-to-back with in_valid/out_ready held high; in_data scribbled during EXEC.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 6'b000111;
      tick();
      for (int s = 1; s <= 5; s++) begin
         chk("b2b first step", 32'(bus.dbg_step), 32'(s));
         if (s == 1) bus.in_data = 6'b110000;
         if (s == 5) bus.in_data = 6'b001000;
         tick();
      end
      chk("b2b first valid", 32'(bus.out_valid), 1);
      chk("b2b first data", 32'(bus.out_data), 32'b101);
      chk("b2b in_ready done", 32'(bus.in_ready), 1);
      tick();
      for (int s = 1; s <= 5; s++) begin
         chk("b2b second step", 32'(bus.dbg_step), 32'(s));
         if (s == 1) bus.in_data = 6'b110000;
         if (s == 5) begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
         end
         tick();
      end
      chk("b2b second valid", 32'(bus.out_valid), 1);
      chk("b2b second data", 32'(bus.out_data), 32'b100);
      tick();
      bus.out_ready = 1'b0;
      chk("b2b to idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);

      // Reset during step 3 abandons the evaluation.
      bus.in_valid = 1'b1;
      bus.in_data  = 6'b000111;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("rst mid dbg_step", 32'(bus.dbg_step), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst mid outputs", 32'({bus.in_ready, bus.out_valid, bus.out_data, bus.dbg_step}), 32'b1_0_000_000);
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      chk("rst mid no out_valid", 32'(seen), 0);
      run_one(6'b000111, 3'b101, "post reset");

      // Reset wins over a simultaneous input handshake.
      bus.in_valid = 1'b1;
      bus.in_data  = 6'b000111;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst vs accept dbg", 32'(bus.dbg_step), 0);
      tick();
      chk("rst vs accept stays idle", 32'({bus.in_ready, bus.dbg_step}), 32'b1_000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
